// File: rtl/sad_pkg.sv
// Shared constants, FSM state type and width helpers for the SAD best-match block.
package sad_pkg;

    localparam int SAD_W        = 12;
    localparam int SUBBLK_DEF   = 4;
    localparam int NUM_CAND_DEF = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } sad_state_e;

    // Cost width grows by log2(SUBBLK) so a full candidate of max SADs cannot overflow.
    function automatic int acc_width(input int sad_w, input int subblk);
        return sad_w + $clog2(subblk);
    endfunction

    function automatic int idx_width(input int num_cand);
        return $clog2(num_cand);
    endfunction

endpackage

// File: rtl/sad_best_match_if.sv
// Upstream 4x4 SAD stream. A beat transfers on a rising clk edge where
// sad_valid && sad_ready; sad_in must be stable while sad_valid is high.
interface sad_best_match_if;
    import sad_pkg::*;

    logic [SAD_W-1:0] sad_in;
    logic             sad_valid;
    logic             sad_ready;

    modport master (output sad_in, output sad_valid, input sad_ready);
    modport slave  (input sad_in, input sad_valid, output sad_ready);

endinterface

// File: rtl/sad_accum.sv
// Sums SUBBLK consecutive 4x4 SADs; total_o includes the current beat so the
// candidate cost is available combinationally on its last beat.
module sad_accum
    import sad_pkg::*;
#(
    parameter int SUBBLK = SUBBLK_DEF,
    parameter int ACC_W  = acc_width(SAD_W, SUBBLK)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             beat_i,
    input  logic [SAD_W-1:0] sad_i,
    output logic [ACC_W-1:0] total_o,
    output logic             last_beat_o
);

    localparam int SUB_W = (SUBBLK > 1) ? $clog2(SUBBLK) : 1;

    logic [ACC_W-1:0] acc_q, acc_d;
    logic [SUB_W-1:0] sub_q, sub_d;

    assign total_o     = acc_q + ACC_W'(sad_i);
    assign last_beat_o = (sub_q == SUB_W'(SUBBLK - 1));

    always_comb begin
        acc_d = acc_q;
        sub_d = sub_q;
        if (clr_i) begin
            acc_d = '0;
            sub_d = '0;
        end else if (beat_i) begin
            if (last_beat_o) begin
                acc_d = '0;
                sub_d = '0;
            end else begin
                acc_d = total_o;
                sub_d = sub_q + SUB_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
            sub_q <= '0;
        end else begin
            acc_q <= acc_d;
            sub_q <= sub_d;
        end
    end

endmodule

// File: rtl/sad_best_match.sv
// Minimum-cost search over NUM_CAND candidates of SUBBLK 4x4 SADs each.
// Optional SAD_EARLY_EXIT_EN adds a thresh port that ends the search early.
module sad_best_match
    import sad_pkg::*;
#(
    parameter  int SUBBLK   = SUBBLK_DEF,
    parameter  int NUM_CAND = NUM_CAND_DEF,
    localparam int ACC_W    = acc_width(SAD_W, SUBBLK),
    localparam int IDX_W    = idx_width(NUM_CAND)
) (
    input  logic             clk,
    input  logic             rst,
    sad_best_match_if.slave  s_if,
    input  logic             start,
`ifdef SAD_EARLY_EXIT_EN
    input  logic [ACC_W-1:0] thresh,
`endif
    output logic             busy,
    output logic [ACC_W-1:0] best_sad,
    output logic [IDX_W-1:0] best_idx,
    output logic             done,
    output sad_state_e       state_dbg
);

    sad_state_e       state_q, state_d;
    logic [IDX_W-1:0] cand_q, cand_d;
    logic [ACC_W-1:0] best_sad_q, best_sad_d;
    logic [IDX_W-1:0] best_idx_q, best_idx_d;
    logic [ACC_W-1:0] total;
    logic             clr, beat, last_beat, cand_last, better, early, leave_run, ready;

    assign clr       = (state_q == IDLE) && start;
    assign beat      = (state_q == RUN) && s_if.sad_valid;
    assign cand_last = (cand_q == IDX_W'(NUM_CAND - 1));
    assign better    = (total < best_sad_q);

`ifdef SAD_EARLY_EXIT_EN
    logic [ACC_W-1:0] thresh_q;

    always_ff @(posedge clk) begin
        if (rst)      thresh_q <= '0;
        else if (clr) thresh_q <= thresh;
    end
    // thresh of 0 can never be beaten, which disables early exit.
    assign early = (total < thresh_q);
`else
    assign early = 1'b0;
`endif

    assign leave_run = beat && last_beat && (cand_last || early);

    sad_accum #(.SUBBLK(SUBBLK), .ACC_W(ACC_W)) u_accum (
        .clk        (clk),
        .rst        (rst),
        .clr_i      (clr),
        .beat_i     (beat),
        .sad_i      (s_if.sad_in),
        .total_o    (total),
        .last_beat_o(last_beat)
    );

    always_comb begin
        state_d = state_q;
        ready   = 1'b0;
        busy    = 1'b0;
        done    = 1'b0;
        unique case (state_q)
            IDLE: if (start) state_d = RUN;
            RUN: begin
                ready = 1'b1;
                busy  = 1'b1;
                if (leave_run) state_d = FIN;
            end
            FIN: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Strict less-than keeps the earliest index on ties.
    always_comb begin
        cand_d     = cand_q;
        best_sad_d = best_sad_q;
        best_idx_d = best_idx_q;
        if (clr) begin
            cand_d     = '0;
            best_sad_d = '1;
            best_idx_d = '0;
        end else if (beat && last_beat) begin
            cand_d = cand_q + IDX_W'(1);
            if (better) begin
                best_sad_d = total;
                best_idx_d = cand_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cand_q     <= '0;
            best_sad_q <= '1;
            best_idx_q <= '0;
        end else begin
            state_q    <= state_d;
            cand_q     <= cand_d;
            best_sad_q <= best_sad_d;
            best_idx_q <= best_idx_d;
        end
    end

    assign s_if.sad_ready = ready;
    assign best_sad       = best_sad_q;
    assign best_idx       = best_idx_q;
    assign state_dbg      = state_q;

endmodule

// File: tb/tb_sad_best_match.sv
// Directed bench for sad_best_match (default SUBBLK=4, NUM_CAND=16); the
// early-exit step is built only when SAD_EARLY_EXIT_EN is defined.
module tb_sad_best_match;
  import sad_pkg::*;

  localparam int ACC_W  = 14;
  localparam int IDX_W  = 4;
  localparam int SUBBLK = 4;
  localparam int NCAND  = 16;
  localparam int NBEATS = SUBBLK * NCAND;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  logic start;
  always #5 clk = ~clk;

  sad_best_match_if sif ();
  logic             busy;
  logic             done;
  logic [ACC_W-1:0] best_sad;
  logic [IDX_W-1:0] best_idx;
  sad_state_e       state_dbg;
`ifdef SAD_EARLY_EXIT_EN
  logic [ACC_W-1:0] thresh;
`endif

  sad_best_match dut (
    .clk      (clk),
    .rst      (rst),
    .s_if     (sif),
    .start    (start),
`ifdef SAD_EARLY_EXIT_EN
    .thresh   (thresh),
`endif
    .busy     (busy),
    .best_sad (best_sad),
    .best_idx (best_idx),
    .done     (done),
    .state_dbg(state_dbg)
  );

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  logic [ACC_W-1:0] exp_q[$];
  int unsigned beat_v[NBEATS];

  always @(posedge clk) if (done === 1'b1) done_cnt <= done_cnt + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // reference: strictly-less minimum over candidate sums, earliest wins
  task automatic model(output int unsigned m_sad, output int m_idx);
    int unsigned s;
    m_sad = 32'h3fff;
    m_idx = 0;
    for (int c = 0; c < NCAND; c++) begin
      s = 0;
      for (int j = 0; j < SUBBLK; j++) s += beat_v[c*SUBBLK + j];
      if (s < m_sad) begin
        m_sad = s;
        m_idx = c;
      end
    end
  endtask

  // driver: n beats; optional idle gap (with an ignored start) before each beat
  task automatic drive_beats(input int n, input bit gaps);
    int unsigned c0;
    c0 = beat_v[0] + beat_v[1] + beat_v[2] + beat_v[3];
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (i == SUBBLK) chk("best_after_cand0", best_sad, c0);
      if (gaps) begin
        sif.sad_valid = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
      end
      sif.sad_valid = 1'b1;
      sif.sad_in = SAD_W'(beat_v[i]);
      chk("beat_ready", sif.sad_ready, 1);
    end
  endtask

  task automatic do_search(input logic [ACC_W-1:0] exp_sad, input int exp_idx, input bit gaps);
    exp_q.push_back(exp_sad);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_in_run", busy, 1);
    drive_beats(NBEATS, gaps);
    @(negedge clk);
    sif.sad_valid = 1'b0;
    chk("done_after_last", done, 1);
    chk("best_sad", best_sad, exp_q.pop_front());
    chk("best_idx", best_idx, exp_idx);
    chk("fin_ready_low", sif.sad_ready, 0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("done_one_cycle", done, 0);
    chk("fin_start_ignored", state_dbg, IDLE);
    chk("best_sad_held", best_sad, exp_sad);
  endtask

  initial begin
    int unsigned m_sad;
    int m_idx;
    int d0;
    rst = 1'b1;
    start = 1'b0;
    sif.sad_valid = 1'b0;
    sif.sad_in = '0;
`ifdef SAD_EARLY_EXIT_EN
    thresh = '0;
`endif

    // reset then idle
    repeat (2) @(negedge clk);
    chk("rst_best_sad", best_sad, 16383);
    chk("rst_best_idx", best_idx, 0);
    chk("rst_ready", sif.sad_ready, 0);
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_state", state_dbg, IDLE);
    rst = 1'b0;
    repeat (4) begin
      @(negedge clk);
      sif.sad_valid = 1'b1;
      sif.sad_in = 12'd7;
      @(negedge clk);
      sif.sad_valid = 1'b0;
    end
    chk("idle_valid_best_sad", best_sad, 16383);
    chk("idle_valid_state", state_dbg, IDLE);
    chk("idle_valid_no_done", done_cnt, 0);

    // monotone costs: candidate k beats are 100+k
    for (int i = 0; i < NBEATS; i++) beat_v[i] = 100 + i / SUBBLK;
    do_search(400, 0, 1'b0);

    // minimum in the middle with a later tie
    for (int i = 0; i < NBEATS; i++) beat_v[i] = 250;
    beat_v[20] = 10; beat_v[21] = 20; beat_v[22] = 30; beat_v[23] = 40;
    for (int j = 0; j < SUBBLK; j++) beat_v[36 + j] = 25;
    do_search(100, 5, 1'b0);

    // max values with valid gaps
    for (int i = 0; i < NBEATS; i++) beat_v[i] = 4095;
    do_search(16380, 0, 1'b1);

    // reset mid-search, then a fresh random search
    for (int i = 0; i < NBEATS; i++) beat_v[i] = $urandom_range(0, 4095);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    drive_beats(30, 1'b0);
    @(negedge clk);
    sif.sad_valid = 1'b0;
    rst = 1'b1;
    d0 = done_cnt;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_best_sad", best_sad, 16383);
    chk("midrst_best_idx", best_idx, 0);
    chk("midrst_ready", sif.sad_ready, 0);
    chk("midrst_state", state_dbg, IDLE);
    repeat (3) @(negedge clk);
    chk("midrst_no_done", done_cnt, d0);
    model(m_sad, m_idx);
    do_search(ACC_W'(m_sad), m_idx, 1'b0);

`ifdef SAD_EARLY_EXIT_EN
    // early exit: thresh 50, candidate 3 costs 40
    for (int i = 0; i < NBEATS; i++) beat_v[i] = (i < 3 * SUBBLK) ? 100 : ((i < 4 * SUBBLK) ? 10 : 5);
    thresh = 14'd50;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    drive_beats(4 * SUBBLK, 1'b0);
    @(negedge clk);
    chk("early_done", done, 1);
    chk("early_best_sad", best_sad, 40);
    chk("early_best_idx", best_idx, 3);
    chk("early_ready_low", sif.sad_ready, 0);
    @(negedge clk);
    sif.sad_valid = 1'b0;
    chk("early_ready_stays_low", sif.sad_ready, 0);
    chk("early_best_held", best_sad, 40);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
